// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the default reset PC, the sequential fetch step, the instruction
// width and a helper that sizes one queue entry as {pc, inst}.
package inst_fetch_queue_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam int unsigned INST_W       = 32;

  // Width of one queue entry: the PC sits above the instruction word.
  function automatic int unsigned entry_w(input int unsigned addr_w);
    return addr_w + INST_W;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used as the fetch queue.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write one entry (ignored while full or flushing)
//   pop              remove the head entry (ignored while empty or flushing)
//   flush            drop all entries and reset both pointers
//   head_valid       queue is not empty
//   head_data        head entry, zero when empty
//   count            occupancy, 0..DEPTH
// Handshake: an entry moves out on a cycle where head_valid and pop are both
// high; push is accepted on any cycle the queue is not full.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are power-of-two wide, so they wrap on their own.
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count says so.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = ~empty;
  assign head_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues reads to the
// instruction SRAM and buffers returned words in a DEPTH-entry queue.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   redirect_valid, redirect_pc    re-steer fetch (branch/jump/exception)
//   inst_sram_en, inst_sram_addr   SRAM read request and address
//   inst_sram_rdata                read data, one cycle after the request
//   out_valid, out_ready           decode handshake on the queue head
//   out_pc, out_inst               head PC and instruction (zero when empty)
//   count                          queue occupancy
// Handshake: the head leaves the queue on any cycle with out_valid and
// out_ready both high, except a redirect cycle, where the pop is ignored.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned        ADDR_W   = ADDR_W_DEF,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned        PC_STEP  = PC_STEP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   inst_sram_en,
  output logic [ADDR_W-1:0]      inst_sram_addr,
  input  logic [31:0]            inst_sram_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [31:0]            out_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned EW    = entry_w(ADDR_W);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              resp_pending_q, resp_pending_d;

  logic              pop, issue;
  logic              fifo_push, fifo_pop, fifo_flush;
  logic [EW-1:0]     head_data;
  logic [CNT_W:0]    occ_after;
  logic              room;

  assign pop = out_valid & out_ready;

  // Slots that will be spoken for once this cycle settles: stored entries
  // plus the response in flight, minus the head leaving. Issuing only while
  // this is below DEPTH keeps every returning response from overflowing.
  assign occ_after = {1'b0, count}
                   + {{CNT_W{1'b0}}, resp_pending_q}
                   - {{CNT_W{1'b0}}, pop};
  assign room      = (occ_after < (CNT_W + 1)'(DEPTH));

  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    req_pc_d       = req_pc_q;
    resp_pending_d = 1'b0;
    issue          = 1'b0;
    inst_sram_addr = fetch_pc_q;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    if (redirect_valid) begin
      // Redirect target goes straight to the SRAM port: no bubble. The
      // response due this cycle and any queued work belong to the old path.
      issue          = 1'b1;
      inst_sram_addr = redirect_pc;
      fetch_pc_d     = redirect_pc + ADDR_W'(PC_STEP);
      req_pc_d       = redirect_pc;
      resp_pending_d = 1'b1;
      fifo_flush     = 1'b1;
    end else begin
      fifo_push = resp_pending_q;
      fifo_pop  = pop;
      if (room) begin
        issue          = 1'b1;
        fetch_pc_d     = fetch_pc_q + ADDR_W'(PC_STEP);
        req_pc_d       = fetch_pc_q;
        resp_pending_d = 1'b1;
      end
    end
  end

  // Reset must silence the SRAM port immediately, not at the next edge.
  assign inst_sram_en = issue & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q     <= RESET_PC;
      req_pc_q       <= '0;
      resp_pending_q <= 1'b0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      req_pc_q       <= req_pc_d;
      resp_pending_q <= resp_pending_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  ({req_pc_q, inst_sram_rdata}),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .head_valid (out_valid),
    .head_data  (head_data),
    .count      (count)
  );

  assign out_pc   = head_data[EW-1:INST_W];
  assign out_inst = head_data[INST_W-1:0];

endmodule
